// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port RAM (combinational read,
// synchronous write). Masters alternate round-robin from idle; a busy owner
// keeps the RAM for at most MAX_BURST accesses while the other master waits.
//
// state | meaning
// IDLE  | no owner, RAM disabled
// OWN0  | m0 (CPU data port) routed to the RAM
// OWN1  | m1 (DMA/debug master) routed to the RAM
module ram_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [3:0]    m0_sel,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [3:0]    m1_sel,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [3:0]    ram_sel,
  output logic [DW-1:0] ram_data_o,
  input  logic [DW-1:0] ram_data_i
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic          last;
  logic [CW-1:0] cnt;
  logic          burst_done;
  logic          owner_entry;

  // The access being acked now is the last one the owner may take in a row.
  assign burst_done  = ({1'b0, cnt} + (CW+1)'(1)) >= (CW+1)'(MAX_BURST);
  assign owner_entry = (state_nxt != state) && (state_nxt != IDLE);

  // Next-state selection: round-robin from idle, hand-over on drop or burst expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) state_nxt = last ? OWN0 : OWN1;
        else if (m0_req)      state_nxt = OWN0;
        else if (m1_req)      state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_req)                   state_nxt = m1_req ? OWN1 : IDLE;
        else if (m1_req && burst_done) state_nxt = OWN1;
      end
      OWN1: begin
        if (!m1_req)                   state_nxt = m0_req ? OWN0 : IDLE;
        else if (m0_req && burst_done) state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Route the owner onto the RAM bus; nothing is driven without an owner.
  always_comb begin
    ram_ce     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_sel    = '0;
    ram_data_o = '0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    case (state)
      OWN0: begin
        ram_addr   = m0_addr;
        ram_sel    = m0_sel;
        ram_data_o = m0_wdata;
        ram_ce     = m0_req;
        ram_we     = m0_req & m0_we;
        m0_ack     = m0_req;
      end
      OWN1: begin
        ram_addr   = m1_addr;
        ram_sel    = m1_sel;
        ram_data_o = m1_wdata;
        ram_ce     = m1_req;
        ram_we     = m1_req & m1_we;
        m1_ack     = m1_req;
      end
      default: ;
    endcase
  end

  assign m0_rdata = m0_ack ? ram_data_i : '0;
  assign m1_rdata = m1_ack ? ram_data_i : '0;

  // State register; reset drops any access in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Ownership history and burst length; last=1 at reset lets m0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
      cnt  <= '0;
    end else if (owner_entry) begin
      last <= (state_nxt == OWN1);
      cnt  <= '0;
    end else if ((m0_ack || m1_ack) && (cnt != CW'(MAX_BURST))) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus a long randomized run checked
// against a turn-based ownership model and a shadow copy of RAM contents.
module tb_ram_arbiter;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_clear = 1'b1;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_data_o, ram_data_i;
  logic [3:0]  ram_sel;

  logic        b_m0_req, b_m1_req;
  logic        b_m0_ack, b_m1_ack, b_ram_ce, b_ram_we;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_ram_addr, b_ram_data_o;
  logic [3:0]  b_ram_sel;

  logic [31:0] mem [16];
  logic [31:0] shadow [16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(32), .DW(32), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  ram_arbiter #(.AW(32), .DW(32), .MAX_BURST(1)) dut_b1 (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_we(1'b0), .m0_addr(32'h0), .m0_sel(4'h0),
    .m0_wdata(32'h0), .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(1'b0), .m1_addr(32'h4), .m1_sel(4'h0),
    .m1_wdata(32'h0), .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .ram_ce(b_ram_ce), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_sel(b_ram_sel),
    .ram_data_o(b_ram_data_o), .ram_data_i(32'h0)
  );

  // Behavioural RAM: combinational read, byte-selected synchronous write.
  assign ram_data_i = mem[ram_addr[5:2]];

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[5:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_masters();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_sel = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_sel = 0; m1_wdata = 0;
    b_m0_req = 0; b_m1_req = 0;
  endtask

  // Returns at posedge+1 with reset just released.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic new_txn(output logic we, output logic [31:0] addr,
                         output logic [3:0] sel, output logic [31:0] wdata);
    logic [31:0] r;
    r     = $urandom();
    addr  = {r[31:6], 2'b00, r[3:0]};
    we    = 1'($urandom_range(0, 1));
    sel   = 4'($urandom_range(0, 15));
    wdata = $urandom();
  endtask

  // Randomized-phase model state: owner (2 = nobody), previous winner,
  // accesses granted to the current owner, and per-master wait lengths.
  int own, prev, run, w0, w1, nxt;
  logic e0, e1, a0, a1;
  logic [3:0] idx;

  initial begin
    idle_masters();
    for (int i = 0; i < 16; i++) shadow[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1;
    b_m0_req = 1; b_m1_req = 1;
    #2;
    chk("rst_outputs", {m0_ack, m1_ack, ram_ce, ram_we, ram_sel, ram_addr, ram_data_o}, '0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, '0);
    chk("rst_b1_outputs", {b_m0_ack, b_m1_ack, b_ram_ce, b_ram_we}, '0);
    @(posedge clk); #1;
    chk("rst_after_edge", {m0_ack, m1_ack, ram_ce, ram_we}, '0);

    // m0 alone writes then reads back
    idle_masters();
    ram_clear = 1'b0;
    rst = 1'b0;
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_sel = 4'hF; m0_wdata = 32'h12345678;
    @(negedge clk);
    chk("s34_idle_cycle", {m0_ack, m1_ack, ram_ce}, 3'b000);
    @(posedge clk); @(negedge clk);
    chk("s34_write_ack", {m0_ack, m1_ack}, 2'b10);
    chk("s34_write_bus", {ram_we, ram_addr, ram_sel, ram_data_o}, {1'b1, 32'h10, 4'hF, 32'h12345678});
    @(posedge clk); #1 m0_req = 0;
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    @(posedge clk); @(negedge clk);
    chk("s34_read_ack", m0_ack, 1'b1);
    chk("s34_read_data", m0_rdata, 32'h12345678);
    @(posedge clk); #1 idle_masters();

    // simultaneous requests: bursts of MB, and strict alternation with MAX_BURST=1
    do_reset();
    m0_req = 1; m0_addr = 32'h0; m1_req = 1; m1_addr = 32'h4;
    b_m0_req = 1; b_m1_req = 1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("s35_burst_%0d", k), {m0_ack, m1_ack}, ((k / MB) % 2) ? 2'b01 : 2'b10);
      chk($sformatf("s36_alternate_%0d", k), {b_m0_ack, b_m1_ack}, (k % 2) ? 2'b01 : 2'b10);
    end
    @(posedge clk); #1 idle_masters();

    // owner m1 drops with and without m0 waiting
    do_reset();
    m1_req = 1; m1_addr = 32'h8;
    @(posedge clk); @(negedge clk);
    chk("s37_m1_owns", {m0_ack, m1_ack}, 2'b01);
    @(posedge clk); #1;
    m1_req = 0; m0_req = 1; m0_addr = 32'hC;
    @(negedge clk);
    chk("s37_drop_cycle", {m0_ack, m1_ack, ram_ce}, 3'b000);
    @(posedge clk); @(negedge clk);
    chk("s37_m0_next", {m0_ack, m1_ack}, 2'b10);
    @(posedge clk); #1;
    m0_req = 0; m1_req = 1;
    @(posedge clk); @(negedge clk);
    chk("s37_m1_again", {m0_ack, m1_ack}, 2'b01);
    @(posedge clk); #1 m1_req = 0;
    @(posedge clk); @(negedge clk);
    chk("s37_idle", {m0_ack, m1_ack, ram_ce, ram_we}, 4'b0000);

    // reset mid-burst during an m1 write
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_sel = 4'hF; m1_wdata = 32'h11112222;
    @(posedge clk); @(negedge clk);
    chk("s38_first_write", {m1_ack, ram_we}, 2'b11);
    @(posedge clk); #1 m1_wdata = 32'h99998888;
    #1;
    chk("s38_second_write", {m1_ack, ram_we}, 2'b11);
    rst = 1'b1;
    #1;
    chk("s38_rst_immediate", {m0_ack, m1_ack, ram_ce, ram_we}, 4'b0000);
    @(posedge clk); #1;
    chk("s38_mem_kept", mem[8], 32'h11112222);
    idle_masters();

    // randomized traffic against the ownership model
    do_reset();
    own = 2; prev = 1; run = 0; w0 = 0; w1 = 0;
    a0 = 0; a1 = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!m0_req || a0) begin
        if ($urandom_range(0, 3) != 0) begin
          m0_req = 1; new_txn(m0_we, m0_addr, m0_sel, m0_wdata);
        end else m0_req = 0;
      end
      if (!m1_req || a1) begin
        if ($urandom_range(0, 2) != 0) begin
          m1_req = 1; new_txn(m1_we, m1_addr, m1_sel, m1_wdata);
        end else m1_req = 0;
      end
      @(negedge clk);
      e0 = (own == 0) && m0_req;
      e1 = (own == 1) && m1_req;
      chk("rnd_acks", {m0_ack, m1_ack}, {e0, e1});
      if (e0)
        chk("rnd_bus_m0", {ram_ce, ram_we, ram_addr, ram_sel, ram_data_o},
            {1'b1, m0_we, m0_addr, m0_sel, m0_wdata});
      else if (e1)
        chk("rnd_bus_m1", {ram_ce, ram_we, ram_addr, ram_sel, ram_data_o},
            {1'b1, m1_we, m1_addr, m1_sel, m1_wdata});
      else
        chk("rnd_ram_off", {ram_ce, ram_we}, 2'b00);
      chk("rnd_rdata0", m0_rdata, e0 ? shadow[m0_addr[5:2]] : 32'h0);
      chk("rnd_rdata1", m1_rdata, e1 ? shadow[m1_addr[5:2]] : 32'h0);

      a0 = m0_ack;
      a1 = m1_ack;
      if (m0_req) begin
        if (a0) w0 = 0;
        else begin
          w0++;
          chk("rnd_wait_m0_bounded", (w0 <= MB + 1), 1'b1);
        end
      end
      if (m1_req) begin
        if (a1) w1 = 0;
        else begin
          w1++;
          chk("rnd_wait_m1_bounded", (w1 <= MB + 1), 1'b1);
        end
      end

      if ((e0 && m0_we) || (e1 && m1_we)) begin
        idx = e0 ? m0_addr[5:2] : m1_addr[5:2];
        for (int b = 0; b < 4; b++)
          if (e0 ? m0_sel[b] : m1_sel[b])
            shadow[idx][8*b +: 8] = e0 ? m0_wdata[8*b +: 8] : m1_wdata[8*b +: 8];
      end

      if (e0 || e1) run++;
      nxt = own;
      if (own == 2) begin
        if (m0_req && m1_req) nxt = 1 - prev;
        else if (m0_req)      nxt = 0;
        else if (m1_req)      nxt = 1;
      end else begin
        if (!(own == 0 ? m0_req : m1_req))
          nxt = (own == 0 ? m1_req : m0_req) ? 1 - own : 2;
        else if ((own == 0 ? m1_req : m0_req) && run >= MB)
          nxt = 1 - own;
      end
      if (nxt != own && nxt != 2) begin
        prev = nxt;
        run  = 0;
      end
      own = nxt;

      @(posedge clk); #1;
    end
    idle_masters();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
